uart_msg_rx: RTL and testbench
==============================

Name: uart_msg_rx

Overview:
- UART receiver and message parser for the 9-byte status frame "GBI<n>-<c>-#<NUL>" that the colour-sensor unit transmits at 115200 baud, 8N1, from a 50 MHz clock.
- Recovers bytes from the serial line and validates the frame field by field.
- Reports the decoded node number and colour code to the host-side logic, along with error and message-count status.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- TIMEOUT_CLKS, 8680, maximum idle gap allowed between bytes of one frame (20 bit periods).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_byte  output  8  last received byte; held until the next byte arrives.
- rx_byte_valid  output  1  one-cycle pulse when rx_byte updates.
- msg_valid  output  1  one-cycle pulse when a complete, correct frame has been received.
- node_num  output  2  digit field of the frame: 1..3. Updated only on msg_valid.
- colour_id  output  2  colour field: 0 = 'M' (red), 1 = 'D' (green), 2 = 'W' (blue). Updated only on msg_valid.
- msg_err  output  1  one-cycle pulse when a frame is aborted.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- msg_count  output  8  number of good frames received; wraps 255 -> 0.

Behaviour:
- Reset: all outputs 0; both FSMs go to their initial state; all counters 0. Reset asserted mid-byte or mid-frame discards all partial state.
- rx is passed through a 2-flop synchroniser whose flops reset to 1. Every reference to rx below means the synchronised signal.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on rx == 0; the baud counter is cleared.
  - START: wait CLKS_PER_BIT/2 (217) cycles, then sample rx. If low -> DATA. If high -> IDLE (glitch rejected; no pulse, no error).
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into a register -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx == 1: rx_byte is loaded and rx_byte_valid pulses in the cycle after the sample.
    - rx == 0: frame_err pulses; rx_byte is unchanged.
    - Both cases -> IDLE. No extra idle bit is required, so back-to-back frames are accepted.
- Parser index idx runs 0..8. Expected bytes per index:
  - 0 'G' 0x47, 1 'B' 0x42, 2 'I' 0x49
  - 3 digit '1'..'3' (0x31..0x33)
  - 4 '-' 0x2D
  - 5 letter 'M'/'D'/'W' (0x4D/0x44/0x57)
  - 6 '-' 0x2D, 7 '#' 0x23, 8 NUL 0x00
- Parser actions on each rx_byte_valid:
  - Byte matches: idx increments; fields 3 and 5 are latched into shadow registers.
  - Byte matches at idx == 8: msg_valid pulses in the same cycle as the parser update. node_num and colour_id load from the shadow registers, msg_count increments, and idx returns to 0.
  - Mismatch at idx == 0: the byte is silently ignored; no msg_err.
  - Mismatch at idx > 0: msg_err pulses. idx goes to 1 if the offending byte is 'G' (resynchronisation), otherwise to 0.
- frame_err while idx > 0: msg_err also pulses in the same cycle and idx returns to 0.
- Timeout: a gap counter runs while idx > 0 and clears on every rx_byte_valid. When it reaches TIMEOUT_CLKS: msg_err pulses, idx returns to 0, and the counter clears.
- Simultaneous events: frame_err and timeout in the same cycle produce a single msg_err pulse.
- msg_valid and msg_err are never asserted in the same cycle.
- The digit/letter pairing is not cross-checked; any combination is valid.
- Arithmetic widths: baud counter 9 bits, gap counter 14 bits, msg_count 8-bit modulo.

Decomposition:
- Shared package uart_msg_pkg:
  - Character constants: CH_G, CH_B, CH_I, CH_DASH, CH_HASH, CH_NUL, CH_M, CH_D, CH_W, CH_1..CH_3.
  - Frame length 9.
  - Colour code constants: COL_RED = 0, COL_GREEN = 1, COL_BLUE = 2.
  - Default CLKS_PER_BIT.
- Sub-module uart_rx_byte: synchroniser and byte FSM. Outputs byte, byte_valid and frame_err.
- The parser and timeout logic stay in uart_msg_rx.

Test Plan:
- Send "GBI1-M-#\0" at 434 clks/bit -> 9 rx_byte_valid pulses; a single msg_valid; node_num = 1, colour_id = 0, msg_count = 1.
- Send "GBI3-W-#\0" then, back-to-back with no idle gap, "GBI2-D-#\0" -> two msg_valid pulses; final node_num = 2, colour_id = 1, msg_count = 2.
- Send "GBGBI2-D-#\0" -> msg_err at the second 'G' (idx resyncs to 1); then msg_valid with node_num = 2, colour_id = 1.
- Send "GBI1-M" followed by a byte whose stop bit is driven low -> frame_err and msg_err pulse in the same cycle; a following good frame is accepted.
- Send "GBI" then idle for 8680 clks -> msg_err exactly once; a 100-clk low glitch on rx -> no byte, no error.
- Assert rst mid-byte of frame 3 of 3 -> all outputs 0; next full frame gives msg_count = 1.
- Send 256 good frames -> msg_count wraps to 0.

Source files
------------

// File: rtl/uart_msg_pkg.sv
// Shared constants, types and helpers for the status-frame UART receiver.
package uart_msg_pkg;

   localparam int FRAME_LEN        = 9;
   localparam int DEF_CLKS_PER_BIT = 434;

   localparam logic [7:0] CH_G    = 8'h47;
   localparam logic [7:0] CH_B    = 8'h42;
   localparam logic [7:0] CH_I    = 8'h49;
   localparam logic [7:0] CH_DASH = 8'h2D;
   localparam logic [7:0] CH_HASH = 8'h23;
   localparam logic [7:0] CH_NUL  = 8'h00;
   localparam logic [7:0] CH_M    = 8'h4D;
   localparam logic [7:0] CH_D    = 8'h44;
   localparam logic [7:0] CH_W    = 8'h57;
   localparam logic [7:0] CH_1    = 8'h31;
   localparam logic [7:0] CH_2    = 8'h32;
   localparam logic [7:0] CH_3    = 8'h33;

   localparam logic [1:0] COL_RED   = 2'd0;
   localparam logic [1:0] COL_GREEN = 2'd1;
   localparam logic [1:0] COL_BLUE  = 2'd2;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   // Maps a colour letter (already validated) to its colour code.
   function automatic logic [1:0] colour_code(input logic [7:0] ch);
      case (ch)
         CH_D:    colour_code = COL_GREEN;
         CH_W:    colour_code = COL_BLUE;
         default: colour_code = COL_RED;
      endcase
   endfunction

   // True when ch is an acceptable byte at frame position idx.
   function automatic logic byte_expected(input logic [3:0] idx, input logic [7:0] ch);
      case (idx)
         4'd0:    byte_expected = (ch == CH_G);
         4'd1:    byte_expected = (ch == CH_B);
         4'd2:    byte_expected = (ch == CH_I);
         4'd3:    byte_expected = (ch == CH_1) || (ch == CH_2) || (ch == CH_3);
         4'd4:    byte_expected = (ch == CH_DASH);
         4'd5:    byte_expected = (ch == CH_M) || (ch == CH_D) || (ch == CH_W);
         4'd6:    byte_expected = (ch == CH_DASH);
         4'd7:    byte_expected = (ch == CH_HASH);
         4'd8:    byte_expected = (ch == CH_NUL);
         default: byte_expected = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser plus start/data/stop FSM.
module uart_rx_byte
   import uart_msg_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   output logic       frame_err_o
);

   localparam logic [8:0] HALF_M1 = 9'(CLKS_PER_BIT / 2 - 1);
   localparam logic [8:0] BIT_M1  = 9'(CLKS_PER_BIT - 1);

   logic      sync1_q, sync2_q;
   rx_state_e state_q, state_d;
   logic [8:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;

   // Synchroniser flops idle high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
      end
   end

   // Next-state logic: sample mid-bit, reject start glitches, check the stop bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 9'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = 9'd0;
            if (!sync2_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = 9'd0;
               bit_d   = 3'd0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = 9'd0;
               shift_d = {sync2_q, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = 9'd0;
               state_d = RX_IDLE;
               if (sync2_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= 9'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_msg_rx.sv
// Status-frame receiver: validates "GBI<n>-<c>-#<NUL>" and reports node/colour.
module uart_msg_rx
   import uart_msg_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int TIMEOUT_CLKS = 8680
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_byte_valid,
   output logic       msg_valid,
   output logic [1:0] node_num,
   output logic [1:0] colour_id,
   output logic       msg_err,
   output logic       frame_err,
   output logic [7:0] msg_count
);

   localparam logic [3:0]  IDX_LAST  = 4'(FRAME_LEN - 1);
   localparam logic [13:0] TIMEOUT_V = 14'(TIMEOUT_CLKS);

   logic [7:0] b_data;
   logic       b_valid, b_ferr;

   logic [3:0]  idx_q, idx_d;
   logic [13:0] gap_q, gap_d;
   logic [1:0]  node_sh_q, node_sh_d, col_sh_q, col_sh_d;
   logic [1:0]  node_q, node_d, col_q, col_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mvalid_q, mvalid_d, merr_q, merr_d, ferr_q;
   logic        busy, timeout;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx),
      .data_o      (b_data),
      .data_valid_o(b_valid),
      .frame_err_o (b_ferr)
   );

   // Parser: advance on matching bytes, abort on mismatch, framing error or idle gap.
   always_comb begin
      idx_d     = idx_q;
      node_sh_d = node_sh_q;
      col_sh_d  = col_sh_q;
      node_d    = node_q;
      col_d     = col_q;
      cnt_d     = cnt_q;
      mvalid_d  = 1'b0;
      merr_d    = 1'b0;
      busy      = (idx_q != 4'd0);
      timeout   = busy && !b_valid && (gap_q == TIMEOUT_V);
      if (b_valid) begin
         if (byte_expected(idx_q, b_data)) begin
            if (idx_q == 4'd3) node_sh_d = b_data[1:0];
            if (idx_q == 4'd5) col_sh_d  = colour_code(b_data);
            if (idx_q == IDX_LAST) begin
               mvalid_d = 1'b1;
               node_d   = node_sh_q;
               col_d    = col_sh_q;
               cnt_d    = cnt_q + 8'd1;
               idx_d    = 4'd0;
            end else begin
               idx_d    = idx_q + 4'd1;
            end
         end else if (busy) begin
            // A stray 'G' is treated as the start of a new frame.
            merr_d = 1'b1;
            idx_d  = (b_data == CH_G) ? 4'd1 : 4'd0;
         end
      end else if ((b_ferr && busy) || timeout) begin
         merr_d = 1'b1;
         idx_d  = 4'd0;
      end
      gap_d = (b_valid || idx_d == 4'd0) ? 14'd0 : gap_q + 14'd1;
   end

   // Parser registers; frame_err is delayed one cycle so it lines up with msg_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= 4'd0;
         gap_q     <= 14'd0;
         node_sh_q <= 2'd0;
         col_sh_q  <= 2'd0;
         node_q    <= 2'd0;
         col_q     <= 2'd0;
         cnt_q     <= 8'd0;
         mvalid_q  <= 1'b0;
         merr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         node_sh_q <= node_sh_d;
         col_sh_q  <= col_sh_d;
         node_q    <= node_d;
         col_q     <= col_d;
         cnt_q     <= cnt_d;
         mvalid_q  <= mvalid_d;
         merr_q    <= merr_d;
         ferr_q    <= b_ferr;
      end
   end

   assign rx_byte       = b_data;
   assign rx_byte_valid = b_valid;
   assign msg_valid     = mvalid_q;
   assign node_num      = node_q;
   assign colour_id     = col_q;
   assign msg_err       = merr_q;
   assign frame_err     = ferr_q;
   assign msg_count     = cnt_q;

endmodule

// File: tb/tb_uart_msg_rx.sv
// Scoreboard bench for uart_msg_rx; bit period shortened so the 256-frame wrap fits the run.
module tb_uart_msg_rx;

   localparam int CPB  = 3;
   localparam int TOUT = 20 * CPB;

   typedef struct packed {
      logic [1:0] node;
      logic [1:0] col;
      logic [7:0] cnt;
   } msg_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_byte_valid, msg_valid, msg_err, frame_err;
   logic [1:0] node_num, colour_id;
   logic [7:0] msg_count;

   logic [7:0] exp_bytes[$];
   msg_t       exp_msgs[$];
   logic [7:0] exp_cnt;

   int n_checks = 0, n_pass = 0;
   int n_bytes = 0, n_mv = 0, n_me = 0, n_fe = 0, n_coinc = 0, n_both = 0;
   int cyc = 0, last_byte_cyc = 0, merr_cyc = 0;

   uart_msg_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .rx_byte      (rx_byte),
      .rx_byte_valid(rx_byte_valid),
      .msg_valid    (msg_valid),
      .node_num     (node_num),
      .colour_id    (colour_id),
      .msg_err      (msg_err),
      .frame_err    (frame_err),
      .msg_count    (msg_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Pops the scoreboard whenever the DUT produces a byte or a message.
   task automatic monitor();
      logic [7:0] eb;
      msg_t       em;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cyc++;
            if (rx_byte_valid) begin
               n_bytes++;
               last_byte_cyc = cyc;
               check_eq("byte_expected", exp_bytes.size() != 0, 1);
               if (exp_bytes.size() != 0) begin
                  eb = exp_bytes.pop_front();
                  check_eq("rx_byte", rx_byte, eb);
               end
            end
            if (msg_valid) begin
               n_mv++;
               check_eq("msg_expected", exp_msgs.size() != 0, 1);
               if (exp_msgs.size() != 0) begin
                  em = exp_msgs.pop_front();
                  check_eq("node_num", node_num, em.node);
                  check_eq("colour_id", colour_id, em.col);
                  check_eq("msg_count", msg_count, em.cnt);
               end
            end
            if (msg_err) begin
               n_me++;
               merr_cyc = cyc;
            end
            if (frame_err) n_fe++;
            if (frame_err && msg_err) n_coinc++;
            if (msg_valid && msg_err) n_both++;
         end
      end
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      if (stop_ok) exp_bytes.push_back(b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok);
      rx = 1'b1;
   endtask

   task automatic send_msg(input logic [1:0] node, input logic [7:0] letter);
      logic [7:0] fr [9];
      msg_t       m;
      fr = '{8'h47, 8'h42, 8'h49, 8'h30 + {6'd0, node}, 8'h2D, letter, 8'h2D, 8'h23, 8'h00};
      exp_cnt = exp_cnt + 8'd1;
      m.node  = node;
      m.col   = (letter == 8'h4D) ? 2'd0 : (letter == 8'h44) ? 2'd1 : 2'd2;
      m.cnt   = exp_cnt;
      exp_msgs.push_back(m);
      for (int i = 0; i < 9; i++) send_byte(fr[i], 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      exp_bytes.delete();
      exp_msgs.delete();
      exp_cnt = 8'd0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      repeat (4 * CPB) @(negedge clk);
      check_eq({tag, "_bytes_left"}, exp_bytes.size(), 0);
      check_eq({tag, "_msgs_left"}, exp_msgs.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_rx_byte"}, rx_byte, 0);
      check_eq({tag, "_pulses"}, {rx_byte_valid, msg_valid, msg_err, frame_err}, 4'b0);
      check_eq({tag, "_node"}, node_num, 0);
      check_eq({tag, "_colour"}, colour_id, 0);
      check_eq({tag, "_count"}, msg_count, 0);
   endtask

   initial begin
      int b0, mv0, me0, fe0, co0;
      fork
         monitor();
      join_none

      // Reset state
      do_reset();
      check_idle_outputs("reset");

      // Single good frame
      b0 = n_bytes; mv0 = n_mv;
      send_msg(2'd1, 8'h4D);
      drain("t1");
      check_eq("t1_byte_pulses", n_bytes - b0, 9);
      check_eq("t1_msg_pulses", n_mv - mv0, 1);
      check_eq("t1_count", msg_count, 1);
      check_eq("t1_node", node_num, 1);
      check_eq("t1_colour", colour_id, 0);

      // Back-to-back frames
      do_reset();
      mv0 = n_mv;
      send_msg(2'd3, 8'h57);
      send_msg(2'd2, 8'h44);
      drain("t2");
      check_eq("t2_msg_pulses", n_mv - mv0, 2);
      check_eq("t2_count", msg_count, 2);
      check_eq("t2_node", node_num, 2);
      check_eq("t2_colour", colour_id, 1);

      // Resynchronisation on a stray 'G'
      do_reset();
      me0 = n_me; mv0 = n_mv;
      send_byte(8'h47, 1'b1);
      send_byte(8'h42, 1'b1);
      send_msg(2'd2, 8'h44);
      drain("t3");
      check_eq("t3_msg_err", n_me - me0, 1);
      check_eq("t3_msg_pulses", n_mv - mv0, 1);
      check_eq("t3_node", node_num, 2);
      check_eq("t3_colour", colour_id, 1);

      // Framing error mid-frame, then recovery
      do_reset();
      me0 = n_me; fe0 = n_fe; co0 = n_coinc;
      send_byte(8'h47, 1'b1);
      send_byte(8'h42, 1'b1);
      send_byte(8'h49, 1'b1);
      send_byte(8'h31, 1'b1);
      send_byte(8'h2D, 1'b1);
      send_byte(8'h4D, 1'b1);
      send_byte(8'h2D, 1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check_eq("t4_frame_err", n_fe - fe0, 1);
      check_eq("t4_msg_err", n_me - me0, 1);
      check_eq("t4_same_cycle", n_coinc - co0, 1);
      send_msg(2'd3, 8'h57);
      drain("t4");
      check_eq("t4_count", msg_count, 1);
      check_eq("t4_node", node_num, 3);

      // Inter-byte timeout, then a short start-bit glitch
      do_reset();
      me0 = n_me;
      send_byte(8'h47, 1'b1);
      send_byte(8'h42, 1'b1);
      send_byte(8'h49, 1'b1);
      repeat (3 * TOUT) @(negedge clk);
      check_eq("t5_timeout_once", n_me - me0, 1);
      check_eq("t5_timeout_window",
               (merr_cyc - last_byte_cyc >= TOUT) && (merr_cyc - last_byte_cyc <= TOUT + 3), 1);
      b0 = n_bytes; me0 = n_me; fe0 = n_fe;
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      check_eq("t5_glitch_bytes", n_bytes - b0, 0);
      check_eq("t5_glitch_errs", (n_me - me0) + (n_fe - fe0), 0);

      // Reset mid-byte of the third frame
      do_reset();
      send_msg(2'd1, 8'h4D);
      send_msg(2'd2, 8'h44);
      send_byte(8'h47, 1'b1);
      send_byte(8'h42, 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      check_eq("t6_count_before", msg_count, 2);
      rst = 1'b1;
      #1;
      check_idle_outputs("t6_reset");
      do_reset();
      send_msg(2'd3, 8'h57);
      drain("t6");
      check_eq("t6_count", msg_count, 1);

      // msg_count wrap after 256 frames
      do_reset();
      mv0 = n_mv;
      for (int i = 0; i < 256; i++) begin
         case (i % 3)
            0:       send_msg(2'd1, 8'h4D);
            1:       send_msg(2'd2, 8'h44);
            default: send_msg(2'd3, 8'h57);
         endcase
      end
      drain("t7");
      check_eq("t7_msg_pulses", n_mv - mv0, 256);
      check_eq("t7_count_wrap", msg_count, 0);

      check_eq("valid_err_overlap", n_both, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
